// File: rtl/ticket_arb_pkg.sv
// Shared types and constants for the ticket kiosk arbiter.
// Optional response timeout is enabled by TICKET_ARB_TIMEOUT_EN.
package ticket_arb_pkg;

    localparam int N_KIOSK        = 4;
    localparam int TIMEOUT_CYCLES = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam logic [1:0] CAT_VIP     = 2'b00;
    localparam logic [1:0] CAT_REGULAR = 2'b01;
    localparam logic [1:0] CAT_STUDENT = 2'b10;
    localparam logic [1:0] CAT_SENIOR  = 2'b11;

    function automatic logic [N_KIOSK-1:0] onehot(input logic [1:0] idx);
        logic [N_KIOSK-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/ticket_rr_picker.sv
// Combinational round-robin picker over the unmasked kiosk requests.
// The first eligible kiosk at or after rr_ptr wins.
module ticket_rr_picker
    import ticket_arb_pkg::*;
(
    input  logic [N_KIOSK-1:0] req,
    input  logic [N_KIOSK-1:0] mask,
    input  logic [1:0]         rr_ptr,
    output logic               grant_valid,
    output logic [1:0]         grant_idx
);

    logic [N_KIOSK-1:0] elig;
    logic [1:0]         idx;

    assign elig = req & ~mask;

    // Scan farthest offset first so the closest eligible kiosk is the last write.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 2'd0;
        idx         = rr_ptr;
        for (int i = N_KIOSK - 1; i >= 0; i--) begin
            idx = rr_ptr + 2'(i);
            if (elig[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/ticket_kiosk_arbiter.sv
// Arbitrates four kiosks onto one ticketing system, one purchase at a time.
// Define TICKET_ARB_TIMEOUT_EN to abandon WAIT after TIMEOUT_CYCLES cycles.
module ticket_kiosk_arbiter
    import ticket_arb_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [N_KIOSK-1:0] kiosk_req,
    input  logic [7:0]         kiosk_cat,
    output logic               purchase_vip,
    output logic               purchase_regular,
    output logic               purchase_student,
    output logic               purchase_senior,
    input  logic               purchase_success,
    input  logic               purchase_failed,
    output logic [N_KIOSK-1:0] kiosk_ack,
    output logic               kiosk_ok,
    output logic               busy,
    output logic               timeout_err
);

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         rr_ptr;
    logic [1:0]         grant_q;
    logic [1:0]         cat_q;
    logic [N_KIOSK-1:0] mask_q;
    logic               result_q;
    logic               grant_valid;
    logic [1:0]         grant_idx;
    logic               got_resp;
    logic               resp_ok;
    logic               timeout_hit;

    assign got_resp = purchase_success | purchase_failed;
    assign resp_ok  = purchase_success & ~purchase_failed;

    ticket_rr_picker u_picker (
        .req         (kiosk_req),
        .mask        (mask_q),
        .rr_ptr      (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

`ifdef TICKET_ARB_TIMEOUT_EN
    logic [2:0] tmo_cnt;
    logic       tmo_q;

    assign timeout_hit = (state == WAIT) && !got_resp
                      && (tmo_cnt == 3'(TIMEOUT_CYCLES - 1));
    assign timeout_err = (state == DONE) && tmo_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
            tmo_q   <= 1'b0;
        end else begin
            tmo_cnt <= (state == WAIT) ? tmo_cnt + 3'd1 : 3'd0;
            tmo_q   <= timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= 2'd0;
            grant_q  <= 2'd0;
            cat_q    <= CAT_VIP;
            mask_q   <= '0;
            result_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                mask_q <= '0;
                if (grant_valid) begin
                    grant_q  <= grant_idx;
                    cat_q    <= kiosk_cat[{grant_idx, 1'b0} +: 2];
                    result_q <= 1'b0;
                end
            end
            if (state == WAIT && got_resp) begin
                result_q <= resp_ok;
            end
            // Hide the served kiosk for one IDLE cycle while it drops its req.
            if (state == DONE) begin
                rr_ptr <= grant_q + 2'd1;
                mask_q <= onehot(grant_q);
            end
        end
    end

    always_comb begin
        state_nxt        = state;
        purchase_vip     = 1'b0;
        purchase_regular = 1'b0;
        purchase_student = 1'b0;
        purchase_senior  = 1'b0;
        kiosk_ack        = '0;
        kiosk_ok         = 1'b0;
        busy             = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (grant_valid) state_nxt = ISSUE;
            end
            ISSUE: begin
                state_nxt = WAIT;
                unique case (cat_q)
                    CAT_VIP:     purchase_vip     = 1'b1;
                    CAT_REGULAR: purchase_regular = 1'b1;
                    CAT_STUDENT: purchase_student = 1'b1;
                    CAT_SENIOR:  purchase_senior  = 1'b1;
                endcase
            end
            WAIT: begin
                if (got_resp || timeout_hit) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
                kiosk_ack = onehot(grant_q);
                kiosk_ok  = result_q;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ticket_kiosk_arbiter.sv
// Scoreboard bench for ticket_kiosk_arbiter; honours TICKET_ARB_TIMEOUT_EN.
module tb_ticket_kiosk_arbiter;
    import ticket_arb_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] kiosk_req = '0;
    logic [7:0] kiosk_cat = '0;
    logic       purchase_vip, purchase_regular;
    logic       purchase_student, purchase_senior;
    logic       purchase_success = 1'b0;
    logic       purchase_failed = 1'b0;
    logic [3:0] kiosk_ack;
    logic       kiosk_ok, busy, timeout_err;
    logic [3:0] pur;

    int n_vec  = 0;
    int n_fail = 0;

    logic [1:0]  exp_pur[$];
    logic [15:0] exp_ack[$];

    ticket_kiosk_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .kiosk_req        (kiosk_req),
        .kiosk_cat        (kiosk_cat),
        .purchase_vip     (purchase_vip),
        .purchase_regular (purchase_regular),
        .purchase_student (purchase_student),
        .purchase_senior  (purchase_senior),
        .purchase_success (purchase_success),
        .purchase_failed  (purchase_failed),
        .kiosk_ack        (kiosk_ack),
        .kiosk_ok         (kiosk_ok),
        .busy             (busy),
        .timeout_err      (timeout_err)
    );

    always #5 clk = ~clk;

    assign pur = {purchase_senior, purchase_student,
                  purchase_regular, purchase_vip};

    function automatic void check(input string name,
                                  input logic [15:0] act,
                                  input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a pulse.
    always @(negedge clk) begin
        logic [1:0]  ec;
        logic [15:0] ea;
        if (!reset) begin
            if (pur != 4'd0) begin
                if (exp_pur.size() == 0) begin
                    check("unexpected purchase", {12'd0, pur}, 16'd0);
                end else begin
                    ec = exp_pur.pop_front();
                    check("purchase", {12'd0, pur}, 16'd1 << ec);
                end
            end
            if (kiosk_ack != 4'd0 || timeout_err) begin
                if (exp_ack.size() == 0) begin
                    check("unexpected ack",
                          {10'd0, timeout_err, kiosk_ok, kiosk_ack}, 16'd0);
                end else begin
                    ea = exp_ack.pop_front();
                    check("ack", {10'd0, timeout_err, kiosk_ok, kiosk_ack}, ea);
                end
            end
        end
    end

    task automatic do_reset();
        reset            = 1'b1;
        kiosk_req        = '0;
        purchase_success = 1'b0;
        purchase_failed  = 1'b0;
        #1;
        check("reset outputs",
              {5'd0, pur, kiosk_ack, kiosk_ok, busy, timeout_err}, 16'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_purchase(input logic [1:0] c);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (pur == 4'd0 && t < 40);
        check("purchase seen", {12'd0, pur}, 16'd1 << c);
    endtask

    task automatic run_txn(input logic [1:0] c, input logic [3:0] ack,
                           input int dly, input logic s, input logic f,
                           input logic drop_early, input logic drop_after);
        int t;
        exp_pur.push_back(c);
        exp_ack.push_back({10'd0, 1'b0, s & ~f, ack});
        wait_purchase(c);
        if (drop_early) kiosk_req = '0;
        repeat (dly) @(posedge clk);
        #1;
        purchase_success = s;
        purchase_failed  = f;
        @(posedge clk);
        #1;
        purchase_success = 1'b0;
        purchase_failed  = 1'b0;
        t = 0;
        while (kiosk_ack == 4'd0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("ack seen", {12'd0, kiosk_ack}, {12'd0, ack});
        if (drop_after) begin
            @(posedge clk);
            #1;
            kiosk_req = kiosk_req & ~ack;
        end
    endtask

    initial begin
        do_reset();

        // Single regular purchase from kiosk 0
        kiosk_cat = 8'b00_00_00_01;
        kiosk_req = 4'b0001;
        run_txn(CAT_REGULAR, 4'b0001, 2, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("idle after txn", {15'd0, busy}, 16'd0);

        // All kiosks held: strict rotation 0,1,2,3,0
        do_reset();
        kiosk_cat = 8'b11_10_01_00;
        kiosk_req = 4'b1111;
        run_txn(CAT_VIP,     4'b0001, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_txn(CAT_REGULAR, 4'b0010, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_txn(CAT_STUDENT, 4'b0100, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_txn(CAT_SENIOR,  4'b1000, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_txn(CAT_VIP,     4'b0001, 1, 1'b1, 1'b0, 1'b0, 1'b1);
        kiosk_req = '0;

        // Senior kiosk 2 fails and drops its req mid-service
        kiosk_cat = 8'b00_11_00_00;
        kiosk_req = 4'b0100;
        run_txn(CAT_SENIOR, 4'b0100, 2, 1'b0, 1'b1, 1'b1, 1'b0);

        // Success and failed together count as failed
        kiosk_cat = 8'b00_00_00_00;
        kiosk_req = 4'b0100;
        run_txn(CAT_VIP, 4'b0100, 1, 1'b1, 1'b1, 1'b0, 1'b1);

        // Stray success while idle
        @(posedge clk);
        #1 purchase_success = 1'b1;
        @(posedge clk);
        #1 purchase_success = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stray ignored", {11'd0, kiosk_ack, busy}, 16'd0);
        end

        // Reset in WAIT abandons the txn and restarts rotation at 0
        kiosk_cat = 8'b00_00_10_00;
        kiosk_req = 4'b0010;
        exp_pur.push_back(CAT_STUDENT);
        wait_purchase(CAT_STUDENT);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async reset outputs",
              {5'd0, pur, kiosk_ack, kiosk_ok, busy, timeout_err}, 16'd0);
        @(negedge clk);
        reset     = 1'b0;
        kiosk_cat = 8'b01_00_00_00;
        kiosk_req = 4'b1001;
        run_txn(CAT_VIP,     4'b0001, 1, 1'b1, 1'b0, 1'b0, 1'b1);
        run_txn(CAT_REGULAR, 4'b1000, 1, 1'b1, 1'b0, 1'b0, 1'b1);

        // No response at all
        kiosk_cat = 8'b00_00_00_00;
        kiosk_req = 4'b0001;
`ifdef TICKET_ARB_TIMEOUT_EN
        begin
            int cnt = 0;
            exp_pur.push_back(CAT_VIP);
            exp_ack.push_back({10'd0, 1'b1, 1'b0, 4'b0001});
            wait_purchase(CAT_VIP);
            do begin
                @(negedge clk);
                cnt++;
            end while (kiosk_ack == 4'd0 && cnt < 30);
            check("timeout latency", 16'(cnt), 16'd9);
            @(posedge clk);
            #1 kiosk_req = '0;
            repeat (2) @(negedge clk);
        end
`else
        exp_pur.push_back(CAT_VIP);
        wait_purchase(CAT_VIP);
        repeat (20) @(negedge clk);
        check("wait forever", {14'd0, timeout_err, busy}, 16'd1);
        do_reset();
`endif

        check("scoreboard drained",
              16'(exp_pur.size() + exp_ack.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
